// File: rtl/spi_gyro_responder.sv
// -----------------------------------------------------------------------------
// spi_gyro_responder
//   SPI mode-3 slave that stands in for the L3G4200D gyroscope on the board
//   SPI link. SCLK/CSN/MOSI are oversampled in the i_clk domain, the command
//   byte is decoded and a small register file is served (WHO_AM_I, CTRL_REG1..5,
//   OUT_TEMP, STATUS, OUT_X/Y/Z). A sample generator feeds new readings.
//
// Ports
//   i_clk           system clock, >= 8x sclk
//   i_rst_n         asynchronous active-low reset
//   i_sclk          SPI clock (idles high)
//   i_csn           chip select, active low
//   i_mosi          master-to-slave data
//   o_miso          slave-to-master data (idles high)
//   i_x_in/y/z      16-bit angular-rate sample
//   i_temp_in       8-bit temperature sample
//   i_sample_valid  one-clk strobe qualifying the sample inputs
//   o_ctrl_reg1/4   current CTRL_REG1 / CTRL_REG4
//   o_cfg_wr        one-clk pulse after a write to 0x20..0x24
//   o_busy          synchronised csn is low
//
// Build option
//   SPI_AUTOINC_EN  when defined, the MS command bit advances the address after
//                   every data byte; otherwise the address never moves.
// -----------------------------------------------------------------------------
module spi_gyro_responder #(
    parameter logic [7:0] WHO_AM_I_VAL = 8'hD3,
    parameter logic [7:0] CTRL1_RST    = 8'h07,
    parameter int         SYNC_STAGES  = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_sclk,
    input  logic        i_csn,
    input  logic        i_mosi,
    output logic        o_miso,
    input  logic [15:0] i_x_in,
    input  logic [15:0] i_y_in,
    input  logic [15:0] i_z_in,
    input  logic [7:0]  i_temp_in,
    input  logic        i_sample_valid,
    output logic [7:0]  o_ctrl_reg1,
    output logic [7:0]  o_ctrl_reg4,
    output logic        o_cfg_wr,
    output logic        o_busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA} state_t;

    state_t r_state, w_state_nxt;

    logic [SYNC_STAGES-1:0] r_sclk_sync, r_csn_sync, r_mosi_sync;
    logic        r_sclk_d, r_csn_d;
    logic [2:0]  r_bit_cnt;
    logic [6:0]  r_rx;
    logic [7:0]  r_tx;
    logic        r_rw;
    logic [5:0]  r_addr;
    logic        r_miso, r_cfg_wr;
    logic [7:0]  r_ctrl1, r_ctrl2, r_ctrl3, r_ctrl4, r_ctrl5;
    logic [15:0] r_out_x, r_out_y, r_out_z, r_pend_x, r_pend_y, r_pend_z;
    logic [7:0]  r_out_temp, r_pend_temp;
    logic        r_pend_vld, r_zyxda, r_zyxor;
`ifdef SPI_AUTOINC_EN
    logic        r_ms;
`endif

    logic        w_sclk_s, w_csn_s, w_mosi_s;
    logic        w_sclk_rise, w_sclk_fall, w_csn_fall, w_active;
    logic [7:0]  w_rx_byte, w_rd_byte;
    logic        w_byte_done, w_cmd_done, w_data_done;
    logic [5:0]  w_next_addr, w_load_addr;
    logic        w_load, w_stat_clr, w_wr;

    // ---------------- synchronisers and edge detection ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sclk_sync <= '1;
            r_csn_sync  <= '1;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b1;
            r_csn_d     <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
            r_csn_sync  <= {r_csn_sync[SYNC_STAGES-2:0],  i_csn};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
            r_sclk_d    <= w_sclk_s;
            r_csn_d     <= w_csn_s;
        end
    end

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_csn_s     = r_csn_sync[SYNC_STAGES-1];
    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
    assign w_csn_fall  = ~w_csn_s & r_csn_d;

    // ---------------- byte framing ----------------
    assign w_active    = (r_state != ST_IDLE) && !w_csn_s;
    assign w_rx_byte   = {r_rx, w_mosi_s};
    assign w_byte_done = w_active && w_sclk_rise && (r_bit_cnt == 3'd7);
    assign w_cmd_done  = w_byte_done && (r_state == ST_CMD);
    assign w_data_done = w_byte_done && (r_state == ST_DATA);

`ifdef SPI_AUTOINC_EN
    assign w_next_addr = r_ms ? r_addr + 6'd1 : r_addr;   // 0x3F wraps to 0x00
`else
    assign w_next_addr = r_addr;
`endif

    // The command byte supplies the first read address directly; later loads
    // use the advanced address.
    assign w_load_addr = (r_state == ST_CMD) ? w_rx_byte[5:0] : w_next_addr;
    assign w_load      = w_cmd_done ? w_rx_byte[7] : (w_data_done && r_rw);
    assign w_stat_clr  = w_load && (w_load_addr == 6'h2D);
    assign w_wr        = w_data_done && !r_rw;

    always_comb begin
        w_rd_byte = 8'h00;
        case (w_load_addr)
            6'h0F:   w_rd_byte = WHO_AM_I_VAL;
            6'h20:   w_rd_byte = r_ctrl1;
            6'h21:   w_rd_byte = r_ctrl2;
            6'h22:   w_rd_byte = r_ctrl3;
            6'h23:   w_rd_byte = r_ctrl4;
            6'h24:   w_rd_byte = r_ctrl5;
            6'h26:   w_rd_byte = r_out_temp;
            6'h27:   w_rd_byte = {r_zyxor, 3'b000, r_zyxda, 3'b000};
            6'h28:   w_rd_byte = r_out_x[7:0];
            6'h29:   w_rd_byte = r_out_x[15:8];
            6'h2A:   w_rd_byte = r_out_y[7:0];
            6'h2B:   w_rd_byte = r_out_y[15:8];
            6'h2C:   w_rd_byte = r_out_z[7:0];
            6'h2D:   w_rd_byte = r_out_z[15:8];
            default: w_rd_byte = 8'h00;
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_csn_fall) w_state_nxt = ST_CMD;
            ST_CMD:  if (w_cmd_done) w_state_nxt = ST_DATA;
            default: w_state_nxt = r_state;
        endcase
        // Deselect aborts from any state; partial bytes are simply dropped.
        if (w_csn_s) w_state_nxt = ST_IDLE;
    end

    // ---------------- shift path ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bit_cnt <= 3'd0;
            r_rx      <= 7'd0;
            r_tx      <= 8'd0;
            r_rw      <= 1'b0;
            r_addr    <= 6'd0;
            r_miso    <= 1'b1;
`ifdef SPI_AUTOINC_EN
            r_ms      <= 1'b0;
`endif
        end else begin
            if (r_state == ST_IDLE || w_csn_s) r_bit_cnt <= 3'd0;
            else if (w_sclk_rise)              r_bit_cnt <= r_bit_cnt + 3'd1;

            if (w_active && w_sclk_rise) r_rx <= w_rx_byte[6:0];

            if (w_cmd_done) begin
                r_rw   <= w_rx_byte[7];
                r_addr <= w_rx_byte[5:0];
`ifdef SPI_AUTOINC_EN
                r_ms   <= w_rx_byte[6];
`endif
            end else if (w_data_done) begin
                r_addr <= w_next_addr;
            end

            if (w_csn_s) begin
                r_miso <= 1'b1;
            end else if (w_load) begin
                r_tx <= w_rd_byte;
            end else if (w_sclk_fall && r_state == ST_DATA && r_rw) begin
                r_miso <= r_tx[7];
                r_tx   <= {r_tx[6:0], 1'b0};
            end
        end
    end

    // ---------------- register file ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ctrl1  <= CTRL1_RST;
            r_ctrl2  <= 8'h00;
            r_ctrl3  <= 8'h00;
            r_ctrl4  <= 8'h00;
            r_ctrl5  <= 8'h00;
            r_cfg_wr <= 1'b0;
        end else begin
            r_cfg_wr <= 1'b0;
            if (w_wr) begin
                case (r_addr)
                    6'h20: begin r_ctrl1 <= w_rx_byte; r_cfg_wr <= 1'b1; end
                    6'h21: begin r_ctrl2 <= w_rx_byte; r_cfg_wr <= 1'b1; end
                    6'h22: begin r_ctrl3 <= w_rx_byte; r_cfg_wr <= 1'b1; end
                    6'h23: begin r_ctrl4 <= w_rx_byte; r_cfg_wr <= 1'b1; end
                    6'h24: begin r_ctrl5 <= w_rx_byte; r_cfg_wr <= 1'b1; end
                    default: ;
                endcase
            end
        end
    end

    // ---------------- samples and STATUS ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_x <= '0; r_out_y <= '0; r_out_z <= '0; r_out_temp <= '0;
            r_pend_x <= '0; r_pend_y <= '0; r_pend_z <= '0; r_pend_temp <= '0;
            r_pend_vld <= 1'b0;
            r_zyxda    <= 1'b0;
            r_zyxor    <= 1'b0;
        end else begin
            // Block data update: hold outputs while selected, keep only the newest.
            if (i_sample_valid && r_ctrl4[7] && !w_csn_s) begin
                r_pend_x <= i_x_in; r_pend_y <= i_y_in; r_pend_z <= i_z_in;
                r_pend_temp <= i_temp_in;
                r_pend_vld  <= 1'b1;
            end else if (i_sample_valid) begin
                r_out_x <= i_x_in; r_out_y <= i_y_in; r_out_z <= i_z_in;
                r_out_temp <= i_temp_in;
                r_pend_vld <= 1'b0;             // a direct sample supersedes any pending one
            end else if (w_csn_s && r_pend_vld) begin
                r_out_x <= r_pend_x; r_out_y <= r_pend_y; r_out_z <= r_pend_z;
                r_out_temp <= r_pend_temp;
                r_pend_vld <= 1'b0;
            end

            // A coincident clear and set leaves ZYXDA set and ZYXOR clear.
            if (i_sample_valid) begin
                r_zyxda <= 1'b1;
                r_zyxor <= w_stat_clr ? 1'b0 : (r_zyxor | r_zyxda);
            end else if (w_stat_clr) begin
                r_zyxda <= 1'b0;
                r_zyxor <= 1'b0;
            end
        end
    end

    assign o_miso      = r_miso;
    assign o_cfg_wr    = r_cfg_wr;
    assign o_busy      = ~w_csn_s;
    assign o_ctrl_reg1 = r_ctrl1;
    assign o_ctrl_reg4 = r_ctrl4;

endmodule

// File: tb/tb_spi_gyro_responder.sv
// -----------------------------------------------------------------------------
// tb_spi_gyro_responder
//   Mode-3 SPI master driving spi_gyro_responder, checked against a
//   transaction-level model of the register map (reads, writes, STATUS flags,
//   block data update). Directed cases first, then randomized operations.
// -----------------------------------------------------------------------------
module tb_spi_gyro_responder;

    localparam int HALF = 8;   // clk cycles per sclk half period

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        sclk = 1'b1, csn = 1'b1, mosi = 1'b0, sample_valid = 1'b0;
    logic [15:0] x_in = '0, y_in = '0, z_in = '0;
    logic [7:0]  temp_in = '0;
    logic        miso, cfg_wr, busy;
    logic [7:0]  ctrl1, ctrl4;

    spi_gyro_responder dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_sclk(sclk), .i_csn(csn), .i_mosi(mosi),
        .o_miso(miso), .i_x_in(x_in), .i_y_in(y_in), .i_z_in(z_in),
        .i_temp_in(temp_in), .i_sample_valid(sample_valid),
        .o_ctrl_reg1(ctrl1), .o_ctrl_reg4(ctrl4), .o_cfg_wr(cfg_wr), .o_busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    int cfg_cnt = 0;
    always @(posedge clk) if (cfg_wr === 1'b1) cfg_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  m_ctrl [5];
    logic [15:0] m_x, m_y, m_z;
    logic [7:0]  m_temp;
    bit          m_da, m_or;
    int          m_cfg = 0;

    task automatic model_reset();
        m_ctrl[0] = 8'h07;
        for (int k = 1; k < 5; k++) m_ctrl[k] = 8'h00;
        m_x = 0; m_y = 0; m_z = 0; m_temp = 0; m_da = 0; m_or = 0;
    endtask

    function automatic logic [7:0] model_read(input int a);
        if (a == 'h0F)              return 8'hD3;
        if (a >= 'h20 && a <= 'h24) return m_ctrl[a - 'h20];
        if (a == 'h26)              return m_temp;
        if (a == 'h27)              return {m_or, 3'b000, m_da, 3'b000};
        if (a == 'h28)              return m_x[7:0];
        if (a == 'h29)              return m_x[15:8];
        if (a == 'h2A)              return m_y[7:0];
        if (a == 'h2B)              return m_y[15:8];
        if (a == 'h2C)              return m_z[7:0];
        if (a == 'h2D)              return m_z[15:8];
        return 8'h00;
    endfunction

    function automatic int model_adv(input int a, input bit ms);
`ifdef SPI_AUTOINC_EN
        if (ms) return (a + 1) % 64;
`endif
        return a;
    endfunction

    task automatic model_sample();
        m_or = m_or | m_da;
        m_da = 1;
        m_x = x_in; m_y = y_in; m_z = z_in; m_temp = temp_in;
    endtask

    // ---------------- SPI master ----------------
    logic [7:0] tx_buf [16];
    logic [7:0] rx_buf [16];
    int         sv_bit = -1;   // bit index at which to strobe sample_valid
    bit         busy_ok;

    task automatic pulse_sample();
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic spi_bit(input logic b, output logic m);
        sclk = 1'b0;
        mosi = b;
        repeat (HALF) @(negedge clk);
        sclk = 1'b1;
        m = miso;
        if (busy !== 1'b1) busy_ok = 0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic spi_xfer(input int nbits);
        logic m;
        csn = 1'b0;
        busy_ok = 1;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == sv_bit) pulse_sample();
            spi_bit(tx_buf[i/8][7-(i%8)], m);
            rx_buf[i/8][7-(i%8)] = m;
        end
        repeat (HALF) @(negedge clk);
        csn = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    // Write: data bytes already in tx_buf[1..n].
    task automatic do_write(input logic [7:0] cmd, input int n);
        int a;
        tx_buf[0] = cmd;
        spi_xfer(8 * (n + 1));
        a = cmd[5:0];
        for (int i = 1; i <= n; i++) begin
            if (a >= 'h20 && a <= 'h24) begin
                m_ctrl[a - 'h20] = tx_buf[i];
                m_cfg++;
            end
            a = model_adv(a, cmd[6]);
        end
        chk("wr_ctrl1", ctrl1, m_ctrl[0]);
        chk("wr_ctrl4", ctrl4, m_ctrl[3]);
        chk("wr_cfg_cnt", cfg_cnt, m_cfg);
    endtask

    // Read: n data bytes; every byte loaded (including the one after the last
    // clocked byte) is accounted for in the model.
    task automatic do_read(input logic [7:0] cmd, input int n);
        int a;
        logic [7:0] v;
        tx_buf[0] = cmd;
        for (int i = 1; i <= n; i++) tx_buf[i] = 8'($urandom);
        spi_xfer(8 * (n + 1));
        a = cmd[5:0];
        for (int i = 0; i <= n; i++) begin
            v = model_read(a);
            if (a == 'h2D) begin m_da = 0; m_or = 0; end
            if (i < n) chk($sformatf("rd_%02h_b%0d", cmd, i), rx_buf[i+1], v);
            a = model_adv(a, cmd[6]);
        end
    endtask

    initial begin
        #20ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] old_xl;
        int c0;
        model_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_miso", miso, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cfg_wr", cfg_wr, 1'b0);
        chk("rst_ctrl1", ctrl1, 8'h07);
        chk("rst_ctrl4", ctrl4, 8'h00);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // WHO_AM_I
        do_read(8'h8F, 1);
        chk("whoami", rx_buf[1], 8'hD3);
        chk("whoami_busy", busy_ok, 1'b1);
        chk("idle_miso", miso, 1'b1);
        chk("idle_busy", busy, 1'b0);

        // Config write and readback
        c0 = cfg_cnt;
        tx_buf[1] = 8'h0F;
        do_write(8'h20, 1);
        chk("cfg_ctrl1", ctrl1, 8'h0F);
        chk("cfg_pulse", cfg_cnt - c0, 1);
        do_read(8'hA0, 1);
        chk("cfg_readback", rx_buf[1], 8'h0F);

        // Burst read of the output registers
        x_in = 16'h1234; y_in = 16'hABCD; z_in = 16'h8001; temp_in = 8'h19;
        pulse_sample(); model_sample();
        repeat (2) @(negedge clk);
        do_read(8'hE8, 6);
`ifdef SPI_AUTOINC_EN
        chk("burst_b5", rx_buf[6], 8'h80);
        do_read(8'hA7, 1);
        chk("burst_status", rx_buf[1], 8'h00);
`else
        chk("burst_b5", rx_buf[6], 8'h34);
        do_read(8'hA7, 1);
        chk("burst_status", rx_buf[1], 8'h08);
`endif

        // Overrun
        pulse_sample(); model_sample();
        pulse_sample(); model_sample();
        repeat (2) @(negedge clk);
        do_read(8'hA7, 1);
        chk("overrun", rx_buf[1], 8'h88);

        // Block data update: X_L holds through the transaction
        tx_buf[1] = 8'h80;
        do_write(8'h23, 1);
        old_xl = model_read('h28);
        x_in = 16'h5A5A;
        sv_bit = 12;
        tx_buf[0] = 8'hA8; tx_buf[1] = 0; tx_buf[2] = 0; tx_buf[3] = 0;
        spi_xfer(32);
        sv_bit = -1;
        chk("bdu_b1", rx_buf[1], old_xl);
        chk("bdu_b2", rx_buf[2], old_xl);
        chk("bdu_b3", rx_buf[3], old_xl);
        model_sample();
        do_read(8'hA8, 1);
        chk("bdu_after", rx_buf[1], 8'h5A);

        // Without BDU the new sample shows up on the next loaded byte
        tx_buf[1] = 8'h00;
        do_write(8'h23, 1);
        x_in = 16'h3CC3;
        sv_bit = 12;
        tx_buf[0] = 8'hA8;
        spi_xfer(32);
        sv_bit = -1;
        chk("nobdu_b1", rx_buf[1], 8'h5A);
        chk("nobdu_b2", rx_buf[2], 8'hC3);
        chk("nobdu_b3", rx_buf[3], 8'hC3);
        model_sample();

        // Abort mid data byte
        c0 = cfg_cnt;
        tx_buf[0] = 8'h21; tx_buf[1] = 8'hFF;
        spi_xfer(13);
        chk("abort_cfg", cfg_cnt - c0, 0);
        do_read(8'hA1, 1);
        chk("abort_ctrl2", rx_buf[1], 8'h00);

        // Read-only / unmapped
        tx_buf[1] = 8'h55;
        do_write(8'h0F, 1);
        do_read(8'h8F, 1);
        chk("ro_whoami", rx_buf[1], 8'hD3);
        do_read(8'hBE, 1);
        chk("unmapped", rx_buf[1], 8'h00);

        // Reset mid-read
        begin
            logic m;
            tx_buf[0] = 8'hA0;
            csn = 1'b0;
            repeat (HALF) @(negedge clk);
            for (int i = 0; i < 12; i++) spi_bit(tx_buf[0][7-(i%8)], m);
            rst_n = 1'b0;
            repeat (2) @(negedge clk);
            chk("mrst_ctrl1", ctrl1, 8'h07);
            chk("mrst_miso", miso, 1'b1);
            csn = 1'b1;
            repeat (4) @(negedge clk);
            rst_n = 1'b1;
            model_reset();
            repeat (4) @(negedge clk);
            do_read(8'h8F, 1);
            chk("mrst_next_cmd", rx_buf[1], 8'hD3);
        end

        // Randomized operations
        for (int op = 0; op < 30; op++) begin
            int kind, n;
            logic [7:0] cmd;
            kind = $urandom_range(0, 2);
            n    = $urandom_range(1, 4);
            if (kind == 0) begin
                x_in = 16'($urandom); y_in = 16'($urandom); z_in = 16'($urandom);
                temp_in = 8'($urandom);
                pulse_sample(); model_sample();
                repeat (2) @(negedge clk);
            end else if (kind == 1) begin
                cmd = {1'b0, 1'($urandom), ($urandom_range(0, 1) == 1) ?
                       6'(8'h20 + $urandom_range(0, 4)) : 6'($urandom)};
                for (int i = 1; i <= n; i++) tx_buf[i] = 8'($urandom);
                do_write(cmd, n);
            end else begin
                cmd = {1'b1, 1'($urandom), ($urandom_range(0, 1) == 1) ?
                       6'(8'h26 + $urandom_range(0, 7)) : 6'($urandom)};
                do_read(cmd, n);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/spi_gyro_responder.md
Name: spi_gyro_responder

Overview:
- Synthesizable SPI slave that models the L3G4200D gyroscope end of the board SPI link (ACL_CSN/ACL_MOSI/ACL_MISO/ACL_SCLK).
- Oversamples SCLK/CSN/MOSI in the system clock domain and decodes the command byte.
- Serves a small register file holding WHO_AM_I, CTRL_REG1..5, OUT_TEMP, STATUS and OUT_X/Y/Z.
- Used as the on-chip/bench counterpart for the existing SPI master and fed by a sample generator.

Parameters:
- WHO_AM_I_VAL, 8'hD3, value returned at address 0x0F.
- CTRL1_RST, 8'h07, reset value of CTRL_REG1 (0x20).
- SYNC_STAGES, 2, synchroniser depth for sclk/csn/mosi (≥2).

Ports:
- clk  in  1  system clock; must be ≥8× sclk frequency.
- rst  in  1  asynchronous, active-low reset.
- sclk  in  1  SPI clock from master; idles high (mode 3).
- csn  in  1  chip select, active low.
- mosi  in  1  master-to-slave data.
- miso  out  1  slave-to-master data.
- x_in, y_in, z_in  in  16 each  new angular-rate sample.
- temp_in  in  8  temperature sample.
- sample_valid  in  1  one-clk strobe; x/y/z/temp valid.
- ctrl_reg1, ctrl_reg4  out  8 each  current configuration registers.
- cfg_wr  out  1  one-clk pulse after any successful write to 0x20–0x24.
- busy  out  1  high while synchronised csn is low.

Behaviour:
- Reset (rst=0):
  - miso=1, cfg_wr=0, busy=0.
  - ctrl_reg1=CTRL1_RST; CTRL_REG2..5=0; OUT/TEMP/STATUS=0; FSM=IDLE.
- Inputs pass through SYNC_STAGES flops. Rise/fall of sclk are detected from the last two synchronised samples; all actions occur in the clk cycle after detection.
- Mode 3:
  - mosi is sampled on sclk rise.
  - miso changes on sclk fall.
  - Bits are MSB first.
- Command byte: bit7 RW (1=read), bit6 MS (auto-increment), bits5:0 address.
- FSM:
  - IDLE: csn fall → CMD, bit count=0.
  - CMD: after the 8th rise, latch RW/MS/addr and go to DATA. If RW=1, load the read byte into the shift register; its bit7 drives miso on the next sclk fall.
  - DATA, write: on each 8th rise, commit the byte to addr if writable and pulse cfg_wr one clk for 0x20–0x24.
  - DATA, read: on each 8th rise, load the next byte.
  - Address advance after each byte: if MS=1, addr+1 wrapping 0x3F→0x00; otherwise addr holds.
  - Any state, csn rise → IDLE, miso=1. A partial byte is discarded and no write occurs.
- Address map:
  - 0x0F: WHO_AM_I (RO).
  - 0x20–0x24: CTRL_REG1..5 (RW).
  - 0x26: OUT_TEMP (RO).
  - 0x27: STATUS (RO).
  - 0x28–0x2D: X_L, X_H, Y_L, Y_H, Z_L, Z_H (RO).
  - Any other address reads 0x00. Writes to RO or unmapped addresses are ignored.
- STATUS:
  - sample_valid sets bit3 (ZYXDA).
  - sample_valid while ZYXDA is already 1 sets bit7 (ZYXOR).
  - Both bits clear when 0x2D is loaded for a read.
  - If a sample_valid and that clear fall in the same cycle, the set wins and ZYXOR is not set.
- Block data update: ctrl_reg4[7]=1 defers OUT/TEMP updates while busy. The newest pending sample is applied on the clk after csn rise; STATUS still sets immediately. With ctrl_reg4[7]=0, outputs update on the clk after sample_valid.
- busy tracks synchronised csn with no added delay.
- Asserting reset mid-transaction aborts immediately. Registers return to reset values and the next csn fall starts a new command.

Optional Feature:
- Macro: SPI_AUTOINC_EN.
- Defined: MS bit honoured as above.
- Undefined: MS bit ignored and addr never advances. Multi-byte reads repeat one register; multi-byte writes rewrite the same register.

Test Plan:
- Read WHO_AM_I: csn low, send 0x8F, clock one more byte → miso returns 0xD3, busy=1 throughout, miso=1 after csn rise.
- Write config: send 0x20 then 0x0F → ctrl_reg1=0x0F, one cfg_wr pulse. Read back with 0xA0 → 0x0F.
- Burst read: sample_valid with x=0x1234, y=0xABCD, z=0x8001, then command 0xE8 plus 6 bytes → 34 12 CD AB 01 80, STATUS bit3 cleared.
  - With SPI_AUTOINC_EN undefined → 34 repeated six times.
- Overrun and BDU:
  - Two sample_valid pulses without a read → STATUS=0x88.
  - With ctrl_reg4=0x80, sample_valid mid-read → OUT_X unchanged until csn rise.
- Aborts:
  - csn rise after 5 bits of a write data byte → target register unchanged, no cfg_wr.
  - rst low mid-read → ctrl_reg1=0x07, miso=1.
- Unmapped/RO: write 0x0F←0x55 then read 0x0F → 0xD3. Read 0x3E → 0x00.
